// File: rtl/remote_comm.sv
// Host-side command initiator: sends a 16-bit command as two UART bytes (high first),
// then waits for a one-byte response or flags a timeout. Includes the 8N1 UART it drives.

module uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [9:0]    r_tx_shift;
    logic [BW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bit;
    logic          r_tx_busy;
    logic          r_tx_done;

    logic          r_rx_ff1;
    logic          r_rx_ff2;
    logic          r_rx_busy;
    logic [BW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_rdy;
    logic [7:0]    r_rx_data;

    // The shifter refills with ones, so its LSB is the idle-high line level.
    assign TX      = r_tx_shift[0];
    assign tx_done = r_tx_done;
    assign rx_rdy  = r_rx_rdy;
    assign rx_data = r_rx_data;

    // Transmit shifter: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= 10'h3FF;
            r_tx_baud  <= '0;
            r_tx_bit   <= 4'd0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else if (trmt && !r_tx_busy) begin
            r_tx_shift <= {1'b1, tx_data, 1'b0};
            r_tx_baud  <= '0;
            r_tx_bit   <= 4'd0;
            r_tx_busy  <= 1'b1;
            r_tx_done  <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_tx_baud == BW'(BAUD_DIV - 1)) begin
                r_tx_baud <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b1;
                end else begin
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_baud <= r_tx_baud + BW'(1);
            end
        end else begin
            r_tx_baud <= '0;
        end
    end

    // Receiver: two-flop synchronizer, mid-bit sampling, rdy set wins over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1   <= 1'b1;
            r_rx_ff2   <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'h00;
            r_rx_rdy   <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_ff1 <= RX;
            r_rx_ff2 <= r_rx_ff1;
            if (clr_rx_rdy) begin
                r_rx_rdy <= 1'b0;
            end
            if (!r_rx_busy) begin
                if (!r_rx_ff2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= BW'(BAUD_DIV / 2);
                    r_rx_bit  <= 4'd0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - BW'(1);
            end else begin
                r_rx_cnt <= BW'(BAUD_DIV - 1);
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_ff2) begin
                        r_rx_busy <= 1'b0;
                    end else begin
                        r_rx_bit <= 4'd1;
                    end
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_ff2) begin
                        r_rx_data <= r_rx_shift;
                        r_rx_rdy  <= 1'b1;
                    end
                end else begin
                    r_rx_shift <= {r_rx_ff2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 4'd1;
                end
            end
        end
    end
endmodule

module remote_comm #(
    parameter int RESP_TO  = 1_000_000,
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        cmd_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        timeout,
    output logic        busy,
    input  logic        RX,
    output logic        TX
);
    localparam int CW = (RESP_TO > 2) ? $clog2(RESP_TO) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_RESP} state_t;

    state_t        r_state;
    logic [15:0]   r_cmd_reg;
    logic          r_go;
    logic          r_trmt;
    logic          r_tx_sel_low;
    logic          r_clr_rx_rdy;
    logic [CW-1:0] r_to_cnt;
    logic          r_cmd_snt;
    logic [7:0]    r_resp;
    logic          r_resp_rdy;
    logic          r_timeout;
    logic          r_busy;

    logic          w_rst_n;
    logic [7:0]    w_tx_data;
    logic          w_tx_done;
    logic          w_rx_rdy;
    logic [7:0]    w_rx_data;
    logic          w_rx_new;

    assign w_rst_n   = ~rst;
    assign w_tx_data = r_tx_sel_low ? r_cmd_reg[7:0] : r_cmd_reg[15:8];
    // rx_rdy is still high in the cycle our clear pulse is out; don't consume it twice.
    assign w_rx_new  = w_rx_rdy & ~r_clr_rx_rdy;

    assign cmd_snt  = r_cmd_snt;
    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;
    assign timeout  = r_timeout;
    assign busy     = r_busy;

    uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .RX         (RX),
        .TX         (TX),
        .trmt       (r_trmt),
        .tx_data    (w_tx_data),
        .tx_done    (w_tx_done),
        .rx_rdy     (w_rx_rdy),
        .rx_data    (w_rx_data),
        .clr_rx_rdy (r_clr_rx_rdy)
    );

    // Command FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cmd_reg    <= 16'h0000;
            r_go         <= 1'b0;
            r_trmt       <= 1'b0;
            r_tx_sel_low <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            r_to_cnt     <= '0;
            r_cmd_snt    <= 1'b0;
            r_resp       <= 8'h00;
            r_resp_rdy   <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_trmt       <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (snd_cmd) begin
                        r_cmd_reg    <= cmd;
                        r_cmd_snt    <= 1'b0;
                        r_resp_rdy   <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_go         <= 1'b1;
                        r_trmt       <= 1'b1;
                        r_tx_sel_low <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= HIGH;
                    end
                end
                HIGH: begin
                    // tx_done from the previous command is still stale on the entry cycle.
                    if (r_go) begin
                        r_go <= 1'b0;
                    end else if (w_tx_done) begin
                        r_trmt       <= 1'b1;
                        r_tx_sel_low <= 1'b1;
                        r_state      <= LOW;
                    end
                end
                LOW: begin
                    if (w_tx_done && !r_trmt) begin
                        r_cmd_snt <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (w_rx_new) begin
                        r_resp       <= w_rx_data;
                        r_resp_rdy   <= 1'b1;
                        r_clr_rx_rdy <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else if (r_to_cnt == CW'(RESP_TO - 1)) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + CW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
            if (w_rx_new && (r_state != WAIT_RESP)) begin
                r_clr_rx_rdy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: TX frames are decoded and checked against
// bytes queued when each command is issued; a device-side UART is modelled on RX.

module tb_remote_comm;
    localparam int RESP_TO  = 100;
    localparam int BAUD_DIV = 8;
    localparam int FRAME    = 10 * BAUD_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        RX = 1'b1;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        timeout;
    logic        busy;
    logic        TX;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rx_lat = 81;
    logic [7:0] tx_q[$];

    remote_comm #(.RESP_TO(RESP_TO), .BAUD_DIV(BAUD_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .snd_cmd  (snd_cmd),
        .cmd      (cmd),
        .cmd_snt  (cmd_snt),
        .resp     (resp),
        .resp_rdy (resp_rdy),
        .timeout  (timeout),
        .busy     (busy),
        .RX       (RX),
        .TX       (TX)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TX frame decoder, sampling each bit at its centre on negedges
    int         mon_cnt = 0;
    bit         mon_busy = 1'b0;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;
    bit         mon_start_ok;
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (TX === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt = 0;
                mon_start_ok = 1'b1;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if ((mon_cnt % BAUD_DIV) == (BAUD_DIV / 2)) begin
                if (mon_cnt / BAUD_DIV == 0) begin
                    mon_start_ok = (TX === 1'b0);
                end else if (mon_cnt / BAUD_DIV <= 8) begin
                    mon_byte[mon_cnt / BAUD_DIV - 1] = TX;
                end else begin
                    vectors++;
                    mon_busy = 1'b0;
                    if (tx_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL tx_frame: got byte %02h, expected no frame", mon_byte);
                    end else begin
                        mon_exp = tx_q.pop_front();
                        if (mon_byte !== mon_exp || TX !== 1'b1 || !mon_start_ok) begin
                            miscompares++;
                            $display("FAIL tx_frame: got %02h start_ok=%0d stop=%b, expected %02h start 0 stop 1",
                                     mon_byte, mon_start_ok, TX, mon_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic do_cmd(input logic [15:0] v, input bit accept);
        snd_cmd = 1'b1;
        cmd = v;
        if (accept) begin
            tx_q.push_back(v[15:8]);
            tx_q.push_back(v[7:0]);
        end
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        cmd = 16'h0000;
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BAUD_DIV) @(posedge clk);
            #1;
        end
        RX = 1'b1;
    endtask

    task automatic wait_for(input int which, input int limit, output int edge_c);
        logic v;
        edge_c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (which)
                0:       v = cmd_snt;
                1:       v = resp_rdy;
                default: v = timeout;
            endcase
            if (v === 1'b1) begin
                edge_c = cyc;
                break;
            end
        end
        if (edge_c < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_sig%0d: still low after %0d cycles, expected 1", which, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cmd_snt, resp, resp_rdy, timeout, busy, TX} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_vals: got snt=%b resp=%02h rdy=%b to=%b busy=%b TX=%b, expected 0 00 0 0 0 1",
                     cmd_snt, resp, resp_rdy, timeout, busy, TX);
        end
    endtask

    task automatic test_send();
        int a;
        int busy_low;
        int c0;
        @(posedge clk);
        #1;
        do_cmd(16'hA55A, 1'b1);
        a = cyc;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: got %b, expected 1", busy);
        end
        busy_low = 0;
        c0 = -1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (cmd_snt === 1'b1) begin
                c0 = cyc;
                break;
            end
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
        end
        vectors++;
        if (c0 < a + 2 * FRAME + 2 || c0 > a + 2 * FRAME + 6) begin
            miscompares++;
            $display("FAIL cmd_snt_time: got %0d cycles after accept, expected about %0d", c0 - a, 2 * FRAME + 3);
        end
        vectors++;
        if (busy_low != 0) begin
            miscompares++;
            $display("FAIL busy_hold: got %0d low cycles, expected 0", busy_low);
        end
        vectors++;
        if (tx_q.size() != 0) begin
            miscompares++;
            $display("FAIL bytes_before_snt: got %0d pending, expected 0", tx_q.size());
        end
    endtask

    task automatic test_loopback();
        int s;
        int r;
        repeat (5) @(posedge clk);
        #1;
        s = cyc;
        send_rx(8'h0A);
        wait_for(1, 20, r);
        rx_lat = (r > s) ? (r - s) : 81;
        vectors++;
        if (resp !== 8'h0A || busy !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL loopback: got resp=%02h busy=%b to=%b, expected 0a 0 0", resp, busy, timeout);
        end
        // back-to-back: request in the very first idle cycle
        do_cmd(16'h1234, 1'b1);
        vectors++;
        if (resp_rdy !== 1'b0 || cmd_snt !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: got rdy=%b snt=%b busy=%b, expected 0 0 1", resp_rdy, cmd_snt, busy);
        end
    endtask

    task automatic test_timeout();
        int c0;
        int t;
        wait_for(0, 4 * FRAME, c0);
        wait_for(2, RESP_TO + 20, t);
        vectors++;
        if (t != c0 + RESP_TO) begin
            miscompares++;
            $display("FAIL timeout_time: got %0d cycles, expected %0d", t - c0, RESP_TO);
        end
        vectors++;
        if (resp_rdy !== 1'b0 || resp !== 8'h0A || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_state: got rdy=%b resp=%02h busy=%b, expected 0 0a 0", resp_rdy, resp, busy);
        end
    endtask

    task automatic test_busy_stray();
        int a;
        int c0;
        int r;
        @(posedge clk);
        #1;
        do_cmd(16'hA55A, 1'b1);
        a = cyc;
        repeat (3) @(posedge clk);
        #1;
        do_cmd(16'hFFFF, 1'b0);
        // stray frame completes while the low byte is on the wire
        while (cyc < a + 5 * BAUD_DIV + 4) begin
            @(posedge clk);
            #1;
        end
        send_rx(8'h33);
        wait_for(0, 2 * FRAME, c0);
        vectors++;
        if (resp !== 8'h0A || resp_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_discard: got resp=%02h rdy=%b, expected 0a 0", resp, resp_rdy);
        end
        repeat (3) @(posedge clk);
        #1;
        send_rx(8'h5A);
        wait_for(1, 20, r);
        vectors++;
        if (resp !== 8'h5A || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL resp_after_stray: got resp=%02h to=%b, expected 5a 0", resp, timeout);
        end
    endtask

    task automatic test_race();
        int c0;
        int r;
        int target;
        @(posedge clk);
        #1;
        do_cmd(16'hC3E1, 1'b1);
        wait_for(0, 4 * FRAME, c0);
        target = c0 + RESP_TO - rx_lat;
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
        send_rx(8'h96);
        wait_for(1, 40, r);
        vectors++;
        if (r != c0 + RESP_TO) begin
            miscompares++;
            $display("FAIL race_align: got rdy at %0d cycles, expected %0d", r - c0, RESP_TO);
        end
        vectors++;
        if (timeout !== 1'b0 || resp !== 8'h96) begin
            miscompares++;
            $display("FAIL race_winner: got to=%b resp=%02h, expected 0 96", timeout, resp);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (timeout !== 1'b0 || resp_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL race_hold: got to=%b rdy=%b, expected 0 1", timeout, resp_rdy);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        @(posedge clk);
        #1;
        do_cmd(16'hA55A, 1'b1);
        repeat (FRAME / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({cmd_snt, resp, resp_rdy, timeout, busy, TX} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset: got snt=%b resp=%02h rdy=%b to=%b busy=%b TX=%b, expected 0 00 0 0 0 1",
                     cmd_snt, resp, resp_rdy, timeout, busy, TX);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete();
        repeat (3) @(posedge clk);
        #1;
        do_cmd(16'h0001, 1'b1);
        wait_for(0, 4 * FRAME, c0);
        vectors++;
        if (tx_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_tx: got %0d pending, expected 0", tx_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_send();
        test_loopback();
        test_timeout();
        test_busy_stray();
        test_race();
        test_reset_mid();
        repeat (5) @(negedge clk);
        vectors++;
        if (tx_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_queue: got %0d pending, expected 0", tx_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
